// File: rtl/i2c_slave_responder_if.sv
// I2C pin and transfer-report bundle for i2c_slave_responder.
// The slave modport is the responder's view; the master modport is the bus/host view.
interface i2c_slave_responder_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic                  scl_i;
  logic                  sda_i;
  logic                  sda_o;
  logic [DATA_WIDTH-1:0] rd_data_i;
  logic                  xfer_valid_o;
  logic                  xfer_op_o;
  logic [ADDR_WIDTH-1:0] xfer_addr_o;
  logic [DATA_WIDTH-1:0] xfer_data_o;
  logic                  busy_o;

  modport slave (
    input  scl_i, sda_i, rd_data_i,
    output sda_o, xfer_valid_o, xfer_op_o, xfer_addr_o, xfer_data_o, busy_o
  );

  modport master (
    output scl_i, sda_i, rd_data_i,
    input  sda_o, xfer_valid_o, xfer_op_o, xfer_addr_o, xfer_data_o, busy_o
  );
endinterface

// File: rtl/i2c_slave_responder.sv
// Oversampled I2C slave: ACKs SLAVE_ADDR, reports each data byte with a one-clk strobe.
// Define I2C_SLAVE_RESPONDER_RDGEN_EN to source read bytes from an internal pattern generator.
module i2c_slave_responder #(
  parameter int                    ADDR_WIDTH = 7,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_slave_responder_if.slave  bus
);

  localparam int SH_W  = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_BITS = CNT_W'(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SH_W-1:0]       sh_q, sh_d, sh_in;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rd_q, rd_d;
  logic                  rw_q, rw_d, sda_q, sda_d, valid_q, valid_d, op_q, op_d, busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] rd_byte;
  logic                  load_rd;

  // Stage p0/p1: metastability guard; stage p2: previous value for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {scl_p0, scl_p1, scl_p2} <= 3'b111;
      {sda_p0, sda_p1, sda_p2} <= 3'b111;
    end else begin
      {scl_p0, scl_p1, scl_p2} <= {bus.scl_i, scl_p0, scl_p1};
      {sda_p0, sda_p1, sda_p2} <= {bus.sda_i, sda_p0, sda_p1};
    end
  end

  // START/STOP require SCL high on both samples so a simultaneous SCL/SDA move is not a condition
  assign scl_rise  =  scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 &  scl_p2;
  assign start_det =  scl_p1 &  scl_p2 & ~sda_p1 &  sda_p2;
  assign stop_det  =  scl_p1 &  scl_p2 &  sda_p1 & ~sda_p2;
  assign sh_in     = {sh_q[SH_W-2:0], sda_p1};

`ifdef I2C_SLAVE_RESPONDER_RDGEN_EN
  logic [6:0] rd_idx_q;
  logic       unused_rd;

  function automatic logic [DATA_WIDTH-1:0] gen_byte(input logic [6:0] idx);
    logic [7:0] v;
    v = (idx < 7'd32) ? 8'd100 + {1'b0, idx} : 8'd95 - {1'b0, idx};
    return DATA_WIDTH'(v);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       rd_idx_q <= '0;
    else if (load_rd) rd_idx_q <= (rd_idx_q == 7'd95) ? 7'd0 : rd_idx_q + 7'd1;
  end

  assign rd_byte   = gen_byte(rd_idx_q);
  assign unused_rd = ^bus.rd_data_i;
`else
  logic unused_load;
  assign rd_byte     = bus.rd_data_i;
  assign unused_load = load_rd;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      tx_q    <= '0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      sda_q   <= 1'b1;
      valid_q <= 1'b0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      sda_q   <= sda_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    rd_d    = rd_q;
    rw_d    = rw_q;
    sda_d   = sda_q;
    valid_d = 1'b0;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    load_rd = 1'b0;
    if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      sda_d   = 1'b1;
      busy_d  = 1'b1;
    end else if (stop_det) begin
      state_d = IDLE;
      cnt_d   = '0;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          sh_d  = sh_in;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == ADDR_LAST) begin
            cnt_d = '0;
            if (sh_in[ADDR_WIDTH:1] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = sh_in[0];
              addr_d  = sh_in[ADDR_WIDTH:1];
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // First SCL fall pulls the ACK low, the second ends the ACK pulse
        ADDR_ACK: if (scl_fall) begin
          if (sda_q) begin
            sda_d = 1'b0;
          end else if (rw_q) begin
            state_d = RD_DATA;
            cnt_d   = '0;
            load_rd = 1'b1;
            rd_d    = rd_byte;
            sda_d   = rd_byte[DATA_WIDTH-1];
            tx_d    = {rd_byte[DATA_WIDTH-2:0], 1'b0};
          end else begin
            state_d = WR_DATA;
            cnt_d   = '0;
            sda_d   = 1'b1;
          end
        end
        WR_DATA: if (scl_rise) begin
          sh_d  = sh_in;
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == DATA_LAST) begin
            state_d = WR_ACK;
            cnt_d   = '0;
            valid_d = 1'b1;
            op_d    = 1'b0;
            data_d  = sh_in[DATA_WIDTH-1:0];
          end
        end
        WR_ACK: if (scl_fall) begin
          if (sda_q) begin
            sda_d = 1'b0;
          end else begin
            sda_d   = 1'b1;
            state_d = WR_DATA;
          end
        end
        // cnt counts bits the master has clocked; the next bit goes out on each fall
        RD_DATA: begin
          if (scl_rise) cnt_d = cnt_q + CNT_ONE;
          if (scl_fall) begin
            if (cnt_q == DATA_BITS) begin
              state_d = RD_ACK;
              sda_d   = 1'b1;
              valid_d = 1'b1;
              op_d    = 1'b1;
              data_d  = rd_q;
            end else begin
              sda_d = tx_q[DATA_WIDTH-1];
              tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end
        RD_ACK: if (scl_rise) begin
          if (!sda_p1) begin
            state_d = RD_DATA;
            cnt_d   = '0;
            load_rd = 1'b1;
            rd_d    = rd_byte;
            tx_d    = rd_byte;
          end else begin
            state_d = IGNORE;
          end
        end
        IGNORE: sda_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.sda_o        = sda_q;
  assign bus.xfer_valid_o = valid_q;
  assign bus.xfer_op_o    = op_q;
  assign bus.xfer_addr_o  = addr_q;
  assign bus.xfer_data_o  = data_q;
  assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: a bit-banged I2C master plus a transfer-strobe monitor.
module tb_i2c_slave_responder;
  localparam int Q = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  i2c_slave_responder_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus ();
  assign bus.scl_i     = scl_m;
  assign bus.sda_i     = sda_m & bus.sda_o;
  assign bus.rd_data_i = rd_data;

  i2c_slave_responder #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .SLAVE_ADDR(7'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       op;
    logic [6:0] addr;
    logic [7:0] data;
  } strb_t;
  strb_t strb_q[$];

  always @(negedge clk)
    if (bus.xfer_valid_o) strb_q.push_back({bus.xfer_op_o, bus.xfer_addr_o, bus.xfer_data_o});

  int checks   = 0;
  int failures = 0;
  int mdl_idx  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_read(input logic [7:0] ext);
    logic [7:0] v;
`ifdef I2C_SLAVE_RESPONDER_RDGEN_EN
    v = (mdl_idx < 32) ? 8'(100 + mdl_idx) : 8'(95 - mdl_idx);
    mdl_idx = (mdl_idx == 95) ? 0 : mdl_idx + 1;
`else
    v = ext;
`endif
    return v;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = bus.sda_i; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    logic x;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(x);
      b[i] = x;
    end
    send_bit(nack);
  endtask

  task automatic xfer(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                      output logic aack, output logic dack, output logic [7:0] rd);
    aack = 1'b1; dack = 1'b1; rd = 8'h00;
    i2c_start;
    write_byte({a, rw}, aack);
    if (aack == 1'b0) begin
      if (!rw) write_byte(wd, dack);
      else     read_byte(rd, 1'b1);
    end
    i2c_stop;
    wait_clk(4);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] rdext;
    logic       exp_aack;
    int         exp_n;
  } vec_t;

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    vec_t       vecs[8];
    logic       aack, dack;
    logic [7:0] rdv, exp_b;
    int         n_rd, n_alt;

    vecs[0] = '{7'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1};
    vecs[1] = '{7'h05, 1'b0, 8'h3C, 8'h00, 1'b1, 0};
    vecs[2] = '{7'h00, 1'b0, 8'hFF, 8'h00, 1'b0, 1};
    vecs[3] = '{7'h00, 1'b1, 8'h00, 8'h5A, 1'b0, 1};
    vecs[4] = '{7'h40, 1'b1, 8'h00, 8'hC3, 1'b1, 0};
    vecs[5] = '{7'h00, 1'b1, 8'h00, 8'h81, 1'b0, 1};
    vecs[6] = '{7'h01, 1'b0, 8'h77, 8'h00, 1'b1, 0};
    vecs[7] = '{7'h00, 1'b0, 8'hA5, 8'h00, 1'b0, 1};
`ifdef I2C_SLAVE_RESPONDER_RDGEN_EN
    n_rd = 32; n_alt = 64;
`else
    n_rd = 4;  n_alt = 8;
`endif

    reset = 1'b0; scl_m = 1'b0; sda_m = 1'b0; rd_data = 8'h00;
    wait_clk(3);
    check("rst_sda_o",   32'(bus.sda_o), 32'd1);
    check("rst_valid",   32'(bus.xfer_valid_o), 32'd0);
    check("rst_op",      32'(bus.xfer_op_o), 32'd0);
    check("rst_addr",    32'(bus.xfer_addr_o), 32'd0);
    check("rst_data",    32'(bus.xfer_data_o), 32'd0);
    check("rst_busy",    32'(bus.busy_o), 32'd0);
    check("rst_state",   32'(dut.state_q), 32'd0);
    check("rst_sync",    32'({dut.scl_p0, dut.scl_p1, dut.scl_p2, dut.sda_p0, dut.sda_p1, dut.sda_p2}),
          32'h3F);
    scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(2);
    reset = 1'b1;
    wait_clk(4);

    for (int i = 0; i < 8; i++) begin
      strb_q.delete();
      rd_data = vecs[i].rdext;
      exp_b   = vecs[i].wdata;
      if (vecs[i].rw && !vecs[i].exp_aack) exp_b = exp_read(vecs[i].rdext);
      xfer(vecs[i].addr, vecs[i].rw, vecs[i].wdata, aack, dack, rdv);
      check($sformatf("vec%0d_addr_ack", i), 32'(aack), 32'(vecs[i].exp_aack));
      check($sformatf("vec%0d_strobes", i), 32'(strb_q.size()), 32'(vecs[i].exp_n));
      if (vecs[i].exp_n != 0 && strb_q.size() != 0) begin
        check($sformatf("vec%0d_op", i),   32'(strb_q[0].op),   32'(vecs[i].rw));
        check($sformatf("vec%0d_addr", i), 32'(strb_q[0].addr), 32'(vecs[i].addr));
        check($sformatf("vec%0d_data", i), 32'(strb_q[0].data), 32'(exp_b));
        if (vecs[i].rw) check($sformatf("vec%0d_bus_rdata", i), 32'(rdv), 32'(exp_b));
        else            check($sformatf("vec%0d_data_ack", i), 32'(dack), 32'd0);
      end
    end

    strb_q.delete();
    for (int i = 0; i < 32; i++) xfer(7'h00, 1'b0, 8'(i), aack, dack, rdv);
    check("wrseq_count", 32'(strb_q.size()), 32'd32);
    for (int i = 0; i < 32; i++)
      if (i < strb_q.size()) check($sformatf("wrseq_data%0d", i), 32'(strb_q[i].data), 32'(i));

    strb_q.delete();
    i2c_start;
    check("busy_after_start", 32'(bus.busy_o), 32'd1);
    write_byte(8'h00, aack);
    check("partial_addr_ack", 32'(aack), 32'd0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop;
    wait_clk(4);
    check("partial_strobes", 32'(strb_q.size()), 32'd0);
    check("busy_after_stop", 32'(bus.busy_o), 32'd0);
    xfer(7'h00, 1'b0, 8'hA5, aack, dack, rdv);
    check("after_partial_strobes", 32'(strb_q.size()), 32'd1);
    if (strb_q.size() != 0) check("after_partial_data", 32'(strb_q[0].data), 32'hA5);

    rd_data = 8'h00;
    exp_b = exp_read(rd_data);
    i2c_start;
    write_byte({7'h00, 1'b1}, aack);
    check("rdrst_addr_ack", 32'(aack), 32'd0);
    check("rdrst_msb_drive", 32'(bus.sda_o), 32'(exp_b[7]));
    check("rdrst_state_rd", 32'(dut.state_q), 32'd5);
    #2 reset = 1'b0;
    #1;
    check("rdrst_sda_async", 32'(bus.sda_o), 32'd1);
    check("rdrst_state_idle", 32'(dut.state_q), 32'd0);
    wait_clk(2);
    sda_m = 1'b1; scl_m = 1'b1;
    wait_clk(2);
    reset = 1'b1;
    mdl_idx = 0;
    wait_clk(4);
    check("rdrst_busy", 32'(bus.busy_o), 32'd0);

    strb_q.delete();
    for (int i = 0; i < n_rd; i++) begin
      rd_data = 8'(i * 37 + 11);
      exp_b = exp_read(rd_data);
      xfer(7'h00, 1'b1, 8'h00, aack, dack, rdv);
      check($sformatf("rdseq%0d", i), 32'(rdv), 32'(exp_b));
    end
    for (int i = 0; i < n_alt; i++) begin
      xfer(7'h00, 1'b0, 8'(64 + i), aack, dack, rdv);
      check($sformatf("alt_wr_ack%0d", i), 32'(dack), 32'd0);
      rd_data = 8'(i * 13 + 5);
      exp_b = exp_read(rd_data);
      xfer(7'h00, 1'b1, 8'h00, aack, dack, rdv);
      check($sformatf("alt_rd%0d", i), 32'(rdv), 32'(exp_b));
    end
    check("rdseq_strobes", 32'(strb_q.size()), 32'(n_rd + 2 * n_alt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 7, meaning the I2C slave address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the I2C data byte width in bits.
REQ-003 SHALL have parameter SLAVE_ADDR, default 7'h00, meaning the address this slave acknowledges.
REQ-004 SHALL have port clk, input, 1 bit, the system clock; SCL/SDA are oversampled on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 SHALL have port scl_i, input, 1 bit, the I2C clock line value (the slave never drives SCL).
REQ-007 SHALL have port sda_i, input, 1 bit, the resolved I2C data line value.
REQ-008 SHALL have port sda_o, output, 1 bit, the open-drain data drive: 0 pulls low, 1 releases.
REQ-009 SHALL have port rd_data_i, input, DATA_WIDTH bits, the external read byte; used only when RDGEN is compiled out.
REQ-010 SHALL have port xfer_valid_o, output, 1 bit, a one-clk strobe per completed data byte.
REQ-011 SHALL have port xfer_op_o, output, 1 bit, the operation: 0 = WRITE, 1 = READ; valid with xfer_valid_o.
REQ-012 SHALL have port xfer_addr_o, output, ADDR_WIDTH bits, the slave address of the current transfer.
REQ-013 SHALL have port xfer_data_o, output, DATA_WIDTH bits, the byte received (WRITE) or sent (READ).
REQ-014 SHALL have port busy_o, output, 1 bit, high from START until STOP.

Function
REQ-015 SHALL pass scl_i and sda_i through 2-flop synchronizers, then detect edges against a third registered copy.
REQ-016 SHALL detect START as a synchronized SDA fall while SCL is high, and STOP as a synchronized SDA rise while SCL is high.
REQ-017 START or repeated START from any state SHALL go to state ADDR with the bit counter cleared; STOP from any state SHALL go to IDLE with sda_o=1.
REQ-018 SHALL use the states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, and IGNORE.
REQ-019 In ADDR, SHALL shift in bits MSB first on the SCL rise, 7 address bits then the R/W bit.
REQ-020 After the 8th ADDR bit, on a match SHALL go to ADDR_ACK; on a mismatch SHALL go to IGNORE and keep sda_o=1 until STOP or START.
REQ-021 sda_o changes SHALL be applied only on a detected SCL fall; worst-case latency is 3 clk after the SCL pin falls.
REQ-022 ADDR_ACK SHALL drive sda_o=0 for one SCL pulse, then go to WR_DATA if R/W=0 or RD_DATA if R/W=1.
REQ-023 In WR_DATA, after 8 bits SHALL pulse xfer_valid_o with op=0 and the byte, then go to WR_ACK, drive the ACK, and return to WR_DATA, supporting multi-byte writes.
REQ-024 On entering RD_DATA, SHALL load the next read byte and drive its bits MSB first on successive SCL falls.
REQ-025 After 8 read bits, SHALL release SDA, pulse xfer_valid_o with op=1, and sample the master ACK on the SCL rise in RD_ACK.
REQ-026 In RD_ACK, SDA=0 (ACK) SHALL continue to the next RD_DATA byte; SDA=1 (NACK) SHALL go to IGNORE.
REQ-027 busy_o SHALL be set on START and cleared on STOP.

Reset
REQ-028 With reset low, SHALL hold state IDLE, sda_o=1, xfer_valid_o=0, xfer_op_o=0, xfer_addr_o=0, xfer_data_o=0, busy_o=0, counters 0, and synchronizer flops at 1.
REQ-029 Reset asserted mid-transfer SHALL release SDA immediately, without waiting for clk.

Configuration
REQ-030 With I2C_SLAVE_RESPONDER_RDGEN_EN defined, SHALL generate read bytes internally: the first 32 READ bytes are 100..131, then 63 decrementing to 0, then repeat the pattern from 100; rd_data_i is ignored.
REQ-031 Without I2C_SLAVE_RESPONDER_RDGEN_EN defined, each read byte SHALL be rd_data_i sampled on entry to RD_DATA.

Verification
REQ-032 Reset, then write 0x00 to address 0 -> ACK on the address and data, one strobe with op=0, addr=0, data=0x00.
REQ-033 Write bytes 0..31 as separate transactions -> 32 strobes with data 0..31 in order.
REQ-034 With RDGEN, 32 single-byte reads -> data 100..131; then 64 alternating writes 64..127 and reads -> reads return 63..0.
REQ-035 Address 0x05 -> SDA stays released on the ACK bit and no strobe is generated.
REQ-036 STOP after 4 data bits, then a new write of 0xA5 -> no strobe for the partial byte, one strobe with 0xA5.
REQ-037 Reset pulled low during RD_DATA while driving 0 -> sda_o=1 asynchronously and state IDLE.
